// File: rtl/proc_pkg.sv
// proc_pkg: shared definitions for the register-file write path.
//   REGSEL_W     - default register-select width (4 destinations).
//   SEL_MAX_W    - widest select any decode site may use.
//   ONEHOT_MAX_N - width of the vector returned by onehot_dec.
//   onehot_dec() - select/enable to one-hot decode. The result is always
//                  ONEHOT_MAX_N bits wide; callers size-cast it to their
//                  own destination count.
package proc_pkg;

  localparam int REGSEL_W     = 2;
  localparam int SEL_MAX_W    = 5;
  localparam int ONEHOT_MAX_N = 1 << SEL_MAX_W;

  function automatic logic [ONEHOT_MAX_N-1:0] onehot_dec(
    input logic [SEL_MAX_W-1:0] sel,
    input logic                 en
  );
    logic [ONEHOT_MAX_N-1:0] v;
    v      = '0;
    v[sel] = en;
    return v;
  endfunction

endpackage

// File: rtl/dec_onehot.sv
// dec_onehot: combinational SEL_W-to-2**SEL_W one-hot decoder with enable.
// Ports:
//   en   in  1          decode enable; dout is all zeros when low
//   sel  in  SEL_W      destination index
//   dout out 2**SEL_W   one-hot strobe
module dec_onehot
  import proc_pkg::*;
#(
  parameter int SEL_W = REGSEL_W
) (
  input  logic                    en,
  input  logic [SEL_W-1:0]        sel,
  output logic [(1 << SEL_W)-1:0] dout
);

  localparam int N = 1 << SEL_W;

  // The shared function decodes into the widest vector; keep the low N bits.
  assign dout = N'(onehot_dec(SEL_MAX_W'(sel), en));

endmodule

// File: rtl/reg_wr_decoder.sv
// reg_wr_decoder: registered two-channel register-file write-select decoder.
// Decodes each channel's (en, sel) into a one-hot write strobe, resolves
// same-destination conflicts (the PRIO1 channel wins), and counts conflicts
// in a saturating counter. All outputs are registered; there is no
// combinational path from inputs to outputs.
// Ports:
//   clk          in  1        system clock, rising edge
//   rst          in  1        synchronous active-high reset
//   en0, sel0    in  1,SEL_W  channel 0 enable and destination
//   en1, sel1    in  1,SEL_W  channel 1 enable and destination
//   stall        in  1        hold all outputs and the counter
//   flush        in  1        zero the strobes next cycle (counter holds)
//   dout0        out N        registered strobe, channel 0
//   dout1        out N        registered strobe, channel 1
//   dout_any     out N        registered dout0 | dout1
//   valid        out 1        registered: any strobe bit set
//   conflict     out 1        registered: strobes came from a conflict
//   conflict_cnt out CNT_W    saturating count of accepted conflicts
// Update priority on each edge: rst > flush > stall > normal decode.
module reg_wr_decoder
  import proc_pkg::*;
#(
  parameter int SEL_W = REGSEL_W,
  parameter int CNT_W = 8,
  parameter bit PRIO1 = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en0,
  input  logic [SEL_W-1:0]        sel0,
  input  logic                    en1,
  input  logic [SEL_W-1:0]        sel1,
  input  logic                    stall,
  input  logic                    flush,
  output logic [(1 << SEL_W)-1:0] dout0,
  output logic [(1 << SEL_W)-1:0] dout1,
  output logic [(1 << SEL_W)-1:0] dout_any,
  output logic                    valid,
  output logic                    conflict,
  output logic [CNT_W-1:0]        conflict_cnt
);

  localparam int N = 1 << SEL_W;

  logic [N-1:0] d0_raw;
  logic [N-1:0] d1_raw;
  logic [N-1:0] d0_nxt;
  logic [N-1:0] d1_nxt;
  logic         hit;

  dec_onehot #(.SEL_W(SEL_W)) u_dec0 (
    .en   (en0),
    .sel  (sel0),
    .dout (d0_raw)
  );

  dec_onehot #(.SEL_W(SEL_W)) u_dec1 (
    .en   (en1),
    .sel  (sel1),
    .dout (d1_raw)
  );

  assign hit = en0 & en1 & (sel0 == sel1);

  // The losing channel is squashed so the two strobes never overlap.
  always_comb begin
    d0_nxt = d0_raw;
    d1_nxt = d1_raw;
    if (hit) begin
      if (PRIO1) d0_nxt = '0;
      else       d1_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout0        <= '0;
      dout1        <= '0;
      dout_any     <= '0;
      valid        <= 1'b0;
      conflict     <= 1'b0;
      conflict_cnt <= '0;
    end else if (flush) begin
      // Counter deliberately holds: a squashed conflict was never accepted.
      dout0    <= '0;
      dout1    <= '0;
      dout_any <= '0;
      valid    <= 1'b0;
      conflict <= 1'b0;
    end else if (!stall) begin
      dout0    <= d0_nxt;
      dout1    <= d1_nxt;
      dout_any <= d0_nxt | d1_nxt;
      valid    <= |(d0_nxt | d1_nxt);
      conflict <= hit;
      if (hit && (conflict_cnt != {CNT_W{1'b1}})) begin
        conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/reg_wr_decoder.md
Name: reg_wr_decoder

Overview:
- Parametrised, registered successor to the 2-to-4 enable decoder.
- Decodes two independent register-file write-select channels (SEL_W-bit select, per-channel enable) into registered one-hot write strobes for 2**SEL_W destinations.
- Resolves same-destination conflicts, supports pipeline stall and flush, and counts conflicts.
- Sits between the write-back stage and the register-file write ports.

Parameters:
- SEL_W, 2, select width; number of decoded outputs N = 2**SEL_W (legal 1..5).
- CNT_W, 8, width of the saturating conflict counter.
- PRIO1, 1, conflict winner: 1 = channel 1 wins, 0 = channel 0 wins.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- en0  in  1  channel 0 write enable.
- sel0  in  SEL_W  channel 0 destination index.
- en1  in  1  channel 1 write enable.
- sel1  in  SEL_W  channel 1 destination index.
- stall  in  1  hold all registered outputs and the counter.
- flush  in  1  squash the stage (outputs to zero next cycle).
- dout0  out  N  registered one-hot strobe, channel 0.
- dout1  out  N  registered one-hot strobe, channel 1.
- dout_any  out  N  registered OR of dout0 and dout1.
- valid  out  1  registered: at least one strobe bit set.
- conflict  out  1  registered: this cycle's strobes came from a same-destination conflict.
- conflict_cnt  out  CNT_W  saturating count of accepted conflicts.

Behaviour:
- Single clock, synchronous active-high reset.
- Reset values: dout0, dout1, dout_any = 0; valid = 0; conflict = 0; conflict_cnt = 0.
- Next-state priority per rising clk edge: rst > flush > stall > normal update.
- Latency: inputs sampled at edge k appear on the outputs after edge k; exactly 1 cycle, no combinational input-to-output path.
- Normal decode: bit sel0 of the dout0 next-value is en0; all other dout0 bits are 0. dout1 is formed the same way from en1/sel1.
- Disabled channel: its strobe vector is all zeros regardless of sel.
- Conflict: en0 & en1 & (sel0 == sel1).
  - PRIO1 = 1: dout0 is forced to all zeros; dout1 is kept.
  - PRIO1 = 0: dout1 is forced to all zeros; dout0 is kept.
  - conflict is registered high for that update.
- Invariant: dout0 & dout1 == 0 at all times. This makes dout_any at most one-hot per channel, with at most 2 bits set.
- dout_any = dout0 | dout1 (registered). valid = |dout_any (registered).
- conflict_cnt increments by 1 on each normal update with a conflict. It saturates at 2**CNT_W-1 (no wrap).
  - Unchanged on stall and on flush.
  - Cleared only by rst.
- stall: all outputs and conflict_cnt hold their previous values; inputs are ignored.
- flush: dout0, dout1, dout_any, valid, conflict go to 0; conflict_cnt holds.
  - flush with stall simultaneously: flush wins.
  - A conflict present on the inputs during flush is not counted.
- rst asserted mid-operation (including during stall) clears everything on that edge. The first post-reset decode happens on the first edge with rst low.
- sel inputs are unconstrained: every SEL_W value is a legal index, so there are no out-of-range cases.

Decomposition:
- Shared package (proc_pkg): REGSEL_W constant, used as the default for SEL_W. Also a function onehot_dec(sel, en) returning an N-bit vector, reusable by other decode sites.
- One sub-module is natural: dec_onehot (parametrised combinational SEL_W-to-N decoder with enable), instantiated twice. The registers, conflict logic and saturating counter live in reg_wr_decoder.

Test Plan:
- Reset, SEL_W=2: rst=1 for 2 cycles with en0=en1=1 -> all outputs 0; after rst drops with sel0=1, sel1=2: dout0=4'b0010, dout1=4'b0100, dout_any=4'b0110, valid=1, conflict=0 one cycle later.
- Conflict, PRIO1=1: en0=en1=1, sel0=sel1=3 -> next cycle dout0=0, dout1=4'b1000, conflict=1, conflict_cnt=1. Repeat with PRIO1=0 -> dout0=4'b1000, dout1=0.
- Stall/flush: load sel0=2 (dout0=4'b0100), then stall=1 for 3 cycles with changing inputs -> outputs and count unchanged; then stall=1 and flush=1 together -> outputs 0, conflict_cnt unchanged.
- Saturation, CNT_W=2: drive 5 consecutive conflicts -> conflict_cnt goes 1,2,3,3,3; a conflict held during flush leaves the count unchanged.
- Enables: en0=0, en1=0 with arbitrary sel -> dout_any=0, valid=0. Sweep all 16 (sel0, sel1) pairs with both enabled and check that dout0 & dout1 == 0 every cycle.
- Width sweep, SEL_W=1 and SEL_W=5: random stimulus against a reference model, 10k cycles, exact match on all outputs including mid-run rst pulses.
